// File: rtl/pipe_dbg_pkg.sv
// Shared types and constants for the pipeline debug-display scanner.
//   scan_state_e : scanner states (IDLE, SCAN, HOLD_ACK)
//   DEF_NSTAGE   : default number of scanned pipeline stages
//   RESET_CHARS  : "--", shown in every field after reset
//   BUBBLE_CHARS : "xx", what the shared decoder returns for a bubble
package pipe_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HOLD_ACK
  } scan_state_e;

  localparam int          DEF_NSTAGE   = 5;
  localparam logic [15:0] RESET_CHARS  = 16'h2D2D;
  localparam logic [15:0] BUBBLE_CHARS = 16'h7878;

endpackage

// File: rtl/scan_refresh_timer.sv
// Auto-refresh timer for the debug scanner (used only when SCAN_AUTO_EN is defined).
// Counts cycles while en=1 and clear=0, wraps at REFRESH-1 and pulses wrap on
// the cycle it wraps. Held at 0 whenever en=0 or clear=1.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable
//   clear      : hold counter at 0
//   wrap       : high during the cycle whose edge wraps the counter
module scan_refresh_timer #(
  parameter int REFRESH = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic wrap
);

  localparam int          CW  = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [CW-1:0] TOP = CW'(REFRESH - 1);

  logic [CW-1:0] cnt;

  assign wrap = en && !clear && (cnt == TOP);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !en) begin
      cnt <= '0;
    end else if (cnt == TOP) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stage_type_scan.sv
// Debug-display scheduler: snapshots every pipeline stage's instruction word and
// bubble flag, feeds them one per cycle to the shared external type decoder, and
// commits the packed 2-char ASCII codes as one string over a req/ack handshake.
// Optional macro SCAN_AUTO_EN adds a free-running refresh that starts frames on
// its own (committed without raising snap_ack).
//   inst_bus/bubble_bus : stage words/flags, stage i at [32*i +: 32] / bit i
//   snap_req/snap_ack   : four-phase display handshake
//   dec_inst/dec_bubble : drive the shared decoder; dec_type is its result
//   type_str            : committed string, stage 0 in the top 16 bits
//   frame_valid         : one-cycle pulse per commit; frame_cnt counts commits
module stage_type_scan
  import pipe_dbg_pkg::*;
#(
  parameter int NSTAGE  = DEF_NSTAGE,
  parameter int REFRESH = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [32*NSTAGE-1:0]  inst_bus,
  input  logic [NSTAGE-1:0]     bubble_bus,
  input  logic                  snap_req,
  output logic                  snap_ack,
  output logic [31:0]           dec_inst,
  output logic                  dec_bubble,
  input  logic [15:0]           dec_type,
  output logic [16*NSTAGE-1:0]  type_str,
  output logic                  frame_valid,
  output logic [7:0]            frame_cnt
);

  localparam int              IW       = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NSTAGE - 1);

  scan_state_e           state, state_nxt;
  logic [IW-1:0]         idx;
  logic [31:0]           snap_inst [NSTAGE];
  logic [NSTAGE-1:0]     snap_bub;
  logic [15:0]           res [NSTAGE];
  logic [16*NSTAGE-1:0]  commit_str;
  logic                  frame_is_auto;
  logic                  start_req, start_auto, last;

  assign last      = (idx == LAST_IDX);
  assign start_req = en && snap_req;

`ifdef SCAN_AUTO_EN
  logic timer_wrap;

  scan_refresh_timer #(.REFRESH(REFRESH)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clear (state != ST_IDLE),
    .wrap  (timer_wrap)
  );

  // A coinciding request wins so the display side still gets its ack.
  assign start_auto = timer_wrap && !snap_req;
`else
  assign start_auto = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path leaves a
  // variable unassigned (which would infer a latch).
  always_comb begin
    state_nxt  = state;
    dec_inst   = '0;
    dec_bubble = 1'b1;
    case (state)
      ST_IDLE:     if (start_req || start_auto) state_nxt = ST_SCAN;
      ST_SCAN: begin
        dec_inst   = snap_inst[idx];
        dec_bubble = snap_bub[idx];
        if (last) state_nxt = frame_is_auto ? ST_IDLE : ST_HOLD_ACK;
      end
      ST_HOLD_ACK: if (!snap_req) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // The last stage's code is still on dec_type at the commit edge, so it is
  // taken live rather than from res.
  always_comb begin
    commit_str = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      commit_str[16*(NSTAGE-1-i) +: 16] = (i == NSTAGE - 1) ? dec_type : res[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      snap_ack      <= 1'b0;
      frame_valid   <= 1'b0;
      frame_cnt     <= '0;
      frame_is_auto <= 1'b0;
      type_str      <= {NSTAGE{RESET_CHARS}};
      snap_bub      <= '1;
      for (int i = 0; i < NSTAGE; i++) snap_inst[i] <= '0;
    end else begin
      state       <= state_nxt;
      frame_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_req || start_auto) begin
            for (int i = 0; i < NSTAGE; i++) snap_inst[i] <= inst_bus[32*i +: 32];
            snap_bub      <= bubble_bus;
            idx           <= '0;
            frame_is_auto <= !start_req;
          end
        end
        ST_SCAN: begin
          if (!last) begin
            idx <= idx + 1'b1;
          end else begin
            type_str    <= commit_str;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 1'b1;
            snap_ack    <= !frame_is_auto;
          end
        end
        ST_HOLD_ACK: if (!snap_req) snap_ack <= 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: the result buffer has no reset: every entry read at commit is
  // rewritten earlier in the same frame, so reset would only cost flops.
  always_ff @(posedge clk) begin
    if (state == ST_SCAN) res[idx] <= dec_type;
  end

endmodule

// File: doc/stage_type_scan.md
# stage_type_scan

Debug-display scheduler for the pipelined CPU: time-shares one external instruction-type decoder across all pipeline stages. Takes an atomic snapshot of every stage's instruction word and bubble flag, then feeds the snapshot to the shared decoder one stage per cycle. It packs the returned 2-character ASCII type codes into one display string and hands it to the display side over a req/ack handshake. Sits between the pipeline registers and the VGA/LCD text driver, beside the single shared decoder instance.

## Interface
- NSTAGE, 5, number of pipeline stages scanned (IF, ID, EX, MEM, WB).
- REFRESH, 1000000, auto-frame period in cycles (used only with SCAN_AUTO_EN).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; new frames start only when high.
- inst_bus  in  32*NSTAGE  stage instruction words, stage i at [32*i+31:32*i].
- bubble_bus  in  NSTAGE  stage bubble flags, bit i = stage i.
- snap_req  in  1  display request, four-phase level.
- snap_ack  out  1  frame committed, held until snap_req low.
- dec_inst  out  32  instruction driven to the shared decoder.
- dec_bubble  out  1  bubble flag driven to the shared decoder.
- dec_type  in  16  combinational decoder result (ASCII pair; "xx" for bubble).
- type_str  out  16*NSTAGE  committed string; stage 0 in the top 16 bits.
- frame_valid  out  1  one-cycle pulse on every commit.
- frame_cnt  out  8  committed-frame counter.

## Operation
- States: IDLE, SCAN, HOLD_ACK.
- IDLE: if en && snap_req, the edge loads snapshots snap_inst[i]<=inst_bus and snap_bub[i]<=bubble_bus. idx<=0; go to SCAN.
- SCAN: dec_inst=snap_inst[idx] and dec_bubble=snap_bub[idx], both combinational from registers. Each edge stores res[idx]<=dec_type.
  - If idx<NSTAGE-1: idx++.
  - Else: type_str<=packed res including the current dec_type; frame_valid<=1; frame_cnt++; snap_ack<=1; go to HOLD_ACK.
- HOLD_ACK: snap_ack stays 1 until snap_req is sampled low, then snap_ack<=0 and go to IDLE.
- Outside SCAN, dec_inst=0 and dec_bubble=1.
- en dropping mid-SCAN does not abort; frames are atomic.
- snap_req dropping mid-SCAN does not abort either; the frame commits and ack then drops on the next edge.
- frame_cnt wraps 255->0 without a flag.

## Timing
- Reset (async, rst_n=0): state=IDLE, idx=0, snap_ack=0, frame_valid=0, frame_cnt=0.
  - Every 16-bit field of type_str = "--" (0x2D2D).
  - Snapshots cleared to 0 with bubbles set.
- Latency: request accepted at edge k, type_str and snap_ack updated at edge k+NSTAGE; snap_ack is visible in cycle k+NSTAGE.
- snap_ack falls one edge after snap_req is sampled low. The earliest next accept is the edge after that (no back-to-back without a low phase).
- type_str is stable between commits; it never shows a partial frame.

## Configuration
- SCAN_AUTO_EN defined:
  - Adds an auto-refresh timer that counts cycles while en=1 and wraps at REFRESH-1.
  - In IDLE, a wrap starts a frame exactly as a request does, but the commit goes to IDLE without raising snap_ack.
  - If the timer wrap and snap_req coincide, the request wins (ack handshake applies) and the timer restarts at 0.
  - The timer is held at 0 while en=0 or while not in IDLE.
- SCAN_AUTO_EN undefined: frames start only from snap_req; no timer logic.

## Structure
- Package pipe_dbg_pkg: state enum (IDLE, SCAN, HOLD_ACK), default NSTAGE, reset character constant "--", bubble text "xx".
- Sub-module scan_refresh_timer (REFRESH parameter, en/clear inputs, wrap pulse output), instantiated only under SCAN_AUTO_EN.
- The decoder stays instantiated in the parent and is wired to dec_inst/dec_bubble/dec_type.

## Test plan
- Reset, then hold idle for 20 cycles -> type_str = ten "--" chars (0x2D2D per stage), snap_ack=0, frame_cnt=0.
- IF=0x00221820 (ADD), ID=0x8C220004 (LW), EX bubble, MEM=0x0C000000 (JAL), WB=0xFC000000 (bad op); pulse-hold snap_req:
  - type_str = "01","0B","xx","1F","FF" (0x3031, 0x3042, 0x7878, 0x3146, 0x4646).
  - snap_ack at edge k+5; frame_cnt=1.
- Change inst_bus every cycle during SCAN -> committed string matches the values sampled at edge k only.
- Keep snap_req high for 30 cycles after ack -> snap_ack stays 1, no second frame. Drop req -> ack falls the next edge.
- Assert rst_n low mid-SCAN (idx=2) -> immediate IDLE, all outputs at reset values, no frame_valid pulse.
- SCAN_AUTO_EN with REFRESH=8, en=1, no requests:
  - frame_valid every 8+5 cycles, snap_ack stays 0.
  - frame_cnt wraps 255->0 after 256 frames.
